if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory address, and loads the IF/ID pipeline register consumed by the ID-stage control decoder. It closes the control loop on the other end of that decoder: it accepts the decoder's Jump request and the ID-resolved beq/bne outcome, redirects the PC, and squashes wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_addr  out  32  instruction address (= PC, combinational from PC register)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- stall  in  1  hazard-unit hold: freeze PC and IF/ID
- id_jump  in  1  decoder Jump for the instruction currently in IF/ID
- id_branch_taken  in  1  beq/bne resolved taken in ID
- id_branch_target  in  32  branch target computed in ID
- if_id_instr  out  32  IF/ID instruction (NOP = 32'h0 when bubble)
- if_id_pc4  out  32  IF/ID PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction

## Operation
- Reset (rst_n=0 at edge): PC=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0. Reset mid-operation discards all in-flight state next edge.
- Normal (stall=0, no redirect): PC<=PC+4; IF/ID<={imem_rdata, PC+4, valid=1}.
- Redirect sources, valid only when if_id_valid=1:
  - branch: id_branch_taken -> target id_branch_target
  - jump: id_jump -> target {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}
- Redirect (stall=0): PC<=target; IF/ID<=bubble (instr 0, pc4 0, valid 0); fetched word squashed.
- Priority: stall > branch > jump > sequential. With stall=1 PC and IF/ID hold; redirect inputs ignored that cycle (ID holds the instruction, so request reasserts).
- id_branch_taken and id_jump both high: branch wins.
- Redirect inputs ignored when if_id_valid=0.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0). Targets have bits [1:0] forced to 0.

## Timing
- imem_addr valid combinationally from PC; no wait states.
- First valid if_id_instr one cycle after rst_n deasserts.
- Taken branch/jump penalty: one bubble; target instruction in IF/ID two edges after the branch/jump entered IF/ID.
- stall held N cycles -> outputs unchanged N cycles; release resumes next edge.

## Configuration
- IF_EARLY_JUMP_EN defined: fetch pre-decodes imem_rdata[31:26]==6'h02; if so (and no stall, no ID branch redirect), PC<={(PC+4)[31:28], imem_rdata[25:0], 2'b00}, the j word enters IF/ID valid, zero bubble. id_jump input ignored. ID branch redirect squashes an early jump in IF.
- Undefined: jumps resolved only via id_jump with one-bubble penalty as above.

## Structure
- Shared package: NOP_INSTR=32'h0, OPC_J=6'h02, default RESET_PC, jump-target helper function (pc4, instr) -> 32-bit target.
- One sub-module: if_jump_predecode (opcode match + target), instantiated only under IF_EARLY_JUMP_EN.

## Test plan
- Reset then free-run with imem = address-indexed words: imem_addr 0,4,8,C; if_id_pc4 4,8,C; if_id_valid 0 then 1.
- beq taken at PC 8, id_branch_target=32'h40: one bubble (valid 0, instr 0), next if_id_pc4=32'h44.
- j 0x100 (32'h0800_0040) at PC 0x10 without macro: one bubble, then PC 0x100; with macro: no bubble, imem_addr 0x100 the cycle after j is fetched.
- stall=1 for 3 cycles mid-stream, id_branch_taken=1 concurrently: PC and IF/ID frozen; redirect taken on first stall=0 cycle.
- id_branch_taken=1 and id_jump=1 together, target 32'h80 vs jump 32'h200: PC=32'h80. Target 32'h83 -> PC 32'h80.
- PC=32'hFFFF_FFFC sequential -> 32'h0; rst_n=0 mid-branch -> PC=RESET_PC, valid 0 next edge.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage of the 5-stage MIPS pipeline.
//   - IF/ID payload struct and its bubble value
//   - NOP encoding, J opcode, default reset PC
//   - jump_target(): pseudo-direct J-format target from PC+4 and the instruction word
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPC_W = 6;

  localparam logic [XLEN-1:0]  NOP_INSTR        = 32'h0000_0000;
  localparam logic [OPC_W-1:0] OPC_J            = 6'h02;
  localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0]  PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0]  WORD_MASK        = 32'hFFFF_FFFC;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0000_0000, valid: 1'b0};

  // J-format target: upper nibble of PC+4, 26-bit word index, word aligned
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc4,
                                                  input logic [XLEN-1:0] instr);
    return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
  endfunction

endpackage

// File: rtl/if_jump_predecode.sv
// Early-jump pre-decoder for the fetch stage.
// Only built with IF_EARLY_JUMP_EN defined; the default build has no use for it.
// Ports:
//   pc4_i        PC+4 of the word being fetched
//   instr_i      word returned by instruction memory
//   is_jump_c_o  combinational: word is a J instruction
//   target_c_o   combinational: J target of that word
`ifdef IF_EARLY_JUMP_EN
module if_jump_predecode
  import if_fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc4_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            is_jump_c_o,
  output logic [XLEN-1:0] target_c_o
);

  // Opcode match on the raw fetch word
  assign is_jump_c_o = (instr_i[31:26] == OPC_J);

  // Target is formed even for non-J words; the caller qualifies it with is_jump_c_o
  assign target_c_o = jump_target(pc4_i, instr_i);

endmodule
`endif

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads IF/ID.
// Redirects come from ID (taken beq/bne, decoder Jump) and squash the wrong-path fetch.
// Priority: stall > branch > jump > sequential.
// Build option: IF_EARLY_JUMP_EN -- J words are pre-decoded at fetch and redirect the PC
//   with no bubble; id_jump is then ignored.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   imem_addr         instruction address (current PC, combinational)
//   imem_rdata        instruction word read at imem_addr
//   stall             hold PC and IF/ID
//   id_jump           decoder Jump for the word in IF/ID
//   id_branch_taken   ID-resolved taken branch
//   id_branch_target  branch target from ID (bits [1:0] dropped)
//   if_id_instr/pc4/valid  registered IF/ID contents
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            id_jump,
  input  logic            id_branch_taken,
  input  logic [XLEN-1:0] id_branch_target,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;

  logic [XLEN-1:0] pc_plus4_c;
  logic            branch_redir_c;
  logic            jump_redir_c;
  logic [XLEN-1:0] jump_tgt_c;

  // Sequential successor, wraps modulo 2^32
  assign pc_plus4_c = pc_q + PC_STEP;

  // ID redirects only count when IF/ID holds a real instruction
  assign branch_redir_c = if_id_q.valid & id_branch_taken;

`ifdef IF_EARLY_JUMP_EN
  // Jumps are taken at fetch from the word just read
  logic unused_id_jump;
  assign unused_id_jump = id_jump;

  if_jump_predecode u_predecode (
    .pc4_i       (pc_plus4_c),
    .instr_i     (imem_rdata),
    .is_jump_c_o (jump_redir_c),
    .target_c_o  (jump_tgt_c)
  );
`else
  // Jumps are resolved by the decoder for the word sitting in IF/ID
  assign jump_redir_c = if_id_q.valid & id_jump;
  assign jump_tgt_c   = jump_target(if_id_q.pc4, if_id_q.instr);
`endif

  // Next PC and IF/ID selection
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    if (!stall) begin
      if (branch_redir_c) begin
        pc_d    = id_branch_target & WORD_MASK;
        if_id_d = IF_ID_BUBBLE;
      end else if (jump_redir_c) begin
        pc_d = jump_tgt_c;
`ifdef IF_EARLY_JUMP_EN
        // The J word itself is a real instruction and proceeds down the pipe
        if_id_d = '{instr: imem_rdata, pc4: pc_plus4_c, valid: 1'b1};
`else
        // The word fetched alongside the jump in ID is wrong-path
        if_id_d = IF_ID_BUBBLE;
`endif
      end else begin
        pc_d    = pc_plus4_c;
        if_id_d = '{instr: imem_rdata, pc4: pc_plus4_c, valid: 1'b1};
      end
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by random redirect/stall traffic.
// Expected PC and IF/ID contents come from an architectural model; a monitor compares.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        id_jump;
  logic        id_branch_taken;
  logic [31:0] id_branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .stall            (stall),
    .id_jump          (id_jump),
    .id_branch_taken  (id_branch_taken),
    .id_branch_target (id_branch_target),
    .if_id_instr      (if_id_instr),
    .if_id_pc4        (if_id_pc4),
    .if_id_valid      (if_id_valid)
  );

  // Instruction memory: address-derived words (never opcode J for the addresses used)
  // plus a few planted J instructions.
  logic [31:0] ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return a ^ 32'h8C00_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Architectural state of the model
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc4   = 32'h0;
  logic        m_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances and its post-edge state is queued
  task automatic step(input bit rst, input bit st, input bit br,
                      input logic [31:0] tgt, input bit jp);
    logic [31:0] w;
    logic [31:0] seq;
    exp_t        x;
    @(negedge clk);
    rst_n            = ~rst;
    stall            = st;
    id_branch_taken  = br;
    id_branch_target = tgt;
    id_jump          = jp;
    w   = mem_word(m_pc);
    seq = m_pc + 32'd4;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      if (m_valid && br) begin
        m_pc = {tgt[31:2], 2'b00};
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
`ifndef IF_EARLY_JUMP_EN
      end else if (m_valid && jp) begin
        m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
`else
      end else if (w[31:26] == 6'h02) begin
        m_pc = {seq[31:28], w[25:0], 2'b00};
        m_instr = w; m_pc4 = seq; m_valid = 1'b1;
`endif
      end else begin
        m_pc = seq;
        m_instr = w; m_pc4 = seq; m_valid = 1'b1;
      end
    end
    x.pc = m_pc; x.instr = m_instr; x.pc4 = m_pc4; x.valid = m_valid;
    exp_q.push_back(x);
  endtask

  task automatic seq_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: every edge the DUT presents a new PC and IF/ID
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_addr",   imem_addr,          e.pc);
      chk("if_id_instr", if_id_instr,        e.instr);
      chk("if_id_pc4",   if_id_pc4,          e.pc4);
      chk("if_id_valid", 32'(if_id_valid),   32'(e.valid));
    end
  end

  initial begin
    ovr[32'h0000_0010] = 32'h0800_0040;  // j 0x100
    ovr[32'h0000_0044] = 32'h0800_0080;  // j 0x200
    rst_n = 1'b0; stall = 1'b0; id_jump = 1'b0;
    id_branch_taken = 1'b0; id_branch_target = 32'h0;

    // Reset and free-run
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    seq_n(3);
    // Branch in IF/ID from PC 8, taken to 0x40
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    seq_n(2);
    // Branch and jump together: branch wins
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
    seq_n(1);
    // Misaligned target is word-aligned
    step(1'b0, 1'b0, 1'b1, 32'h83, 1'b0);
    seq_n(2);

    // Jump to 0x100 from PC 0x10
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    seq_n(5);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    seq_n(2);

    // Stall three cycles with a pending branch, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    seq_n(2);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    seq_n(4);

    // Reset during a branch redirect
    step(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
    seq_n(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0,
           $urandom & 32'h0000_0FFF,
           $urandom_range(0, 9) == 0);
    end

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
